pim_input_buffer: RTL

Double-buffered input staging block that feeds the PIM array. The core side writes 32-bit words sequentially; the block assembles each group into a 1024-bit vector in one of two ping-pong banks. It presents completed vectors to the PIM macro over a valid/ready handshake, so a new vector can be filled while the previous one is being consumed. It is the write-side counterpart of the PIM output buffer in the peripheral module set.

---
 rtl/pim_peri_pkg.sv | 26 ++
 rtl/pim_input_bank.sv | 43 ++++
 rtl/pim_input_buffer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pim_peri_pkg.sv
// Shared definitions for the PIM peripheral modules (input and output buffers).
// Holds the default vector/word geometry, the bank state encoding and a
// helper for sizing word-index and counter fields.
package pim_peri_pkg;

  // Default PIM input vector width and core word width
  localparam int PIM_VEC_W  = 1024;
  localparam int PIM_DATA_W = 32;

  // Number of core words that make up one PIM vector
  localparam int PIM_WORDS  = PIM_VEC_W / PIM_DATA_W;

  // Life cycle of one ping-pong bank
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

  // Width of a word index / fill counter; never narrower than one bit so a
  // single-word configuration still elaborates.
  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/pim_input_bank.sv
// One VEC_W-wide staging bank of the PIM input buffer.
// Word-indexed write port, a full clear, and a truncate port that zeroes
// every word at or above a given index (used when a partial vector is
// committed so that unwritten words read as zero). A write to a word takes
// priority over the truncate of that same word, so a word written in the
// commit cycle survives.
module pim_input_bank
  import pim_peri_pkg::*;
#(
  parameter int DATA_W = PIM_DATA_W,
  parameter int VEC_W  = PIM_VEC_W,
  localparam int WORDS = VEC_W / DATA_W,
  localparam int IDX_W = idx_w(VEC_W / DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              clr_i,
  input  logic              trunc_en_i,
  input  logic [IDX_W-1:0]  trunc_from_i,
  output logic [VEC_W-1:0]  data_o
);

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
    logic [DATA_W-1:0] word_reg;

    // Per-word register: reset/clear, indexed write, then truncate
    always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
        word_reg <= '0;
      end else if (wr_en_i && (wr_idx_i == IDX_W'(gi))) begin
        word_reg <= wr_data_i;
      end else if (trunc_en_i && (IDX_W'(gi) >= trunc_from_i)) begin
        word_reg <= '0;
      end
    end

    assign data_o[gi*DATA_W +: DATA_W] = word_reg;
  end

endmodule

// File: rtl/pim_input_buffer.sv
// Double-buffered (ping-pong) input staging for the PIM array.
// Core writes DATA_W-bit words sequentially into the bank selected by
// wr_ptr; once WORDS words are in, the bank becomes FULL and is offered to
// the PIM macro over pim_valid_o/pim_ready_i while the other bank fills.
// Drain order always equals fill order because both pointers just toggle.
//
// Optional feature: define PIM_INPUT_BUFFER_PARTIAL_COMMIT_EN to add the
// commit_i port, which closes a partially filled bank early (unwritten
// upper words read as zero).
module pim_input_buffer
  import pim_peri_pkg::*;
#(
  parameter int DATA_W = PIM_DATA_W,
  parameter int VEC_W  = PIM_VEC_W,
  localparam int WORDS = VEC_W / DATA_W,
  localparam int CNT_W = idx_w(VEC_W / DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_valid_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  input  logic              flush_i,
`ifdef PIM_INPUT_BUFFER_PARTIAL_COMMIT_EN
  input  logic              commit_i,
`endif
  output logic              pim_valid_o,
  output logic [VEC_W-1:0]  pim_data_o,
  input  logic              pim_ready_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  fill_cnt_o
);

  // Registered control state and its next values
  bank_state_e      state_reg [2];
  bank_state_e      state_next [2];
  logic             wr_ptr_reg, wr_ptr_next;
  logic             rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] fill_cnt_reg, fill_cnt_next;

  // Per-cycle events
  logic             accept;
  logic             drain;
  logic             completes;
  logic             commit_eff;
  logic             flush_clr;
  logic [CNT_W:0]   cnt_plus;
  logic [VEC_W-1:0] bank_data [2];

  // A flush always beats a write in the same cycle
  assign accept    = wr_valid_i && wr_ready_o && !flush_i;
  assign drain     = pim_valid_o && pim_ready_i;
  assign cnt_plus  = {1'b0, fill_cnt_reg} + (CNT_W+1)'(1);
  assign completes = accept && (cnt_plus == (CNT_W+1)'(WORDS));

  // Only a bank that is still being filled (or idle) may be wiped by flush
  assign flush_clr = flush_i && (state_reg[wr_ptr_reg] != FULL);

`ifdef PIM_INPUT_BUFFER_PARTIAL_COMMIT_EN
  // Commit closes the bank after any same-cycle write; it is a no-op when
  // nothing is in the bank or when the write already completed it.
  assign commit_eff = commit_i && !flush_i && !completes &&
                      ((fill_cnt_reg != '0) || accept);
`else
  assign commit_eff = 1'b0;
`endif

  // Control register update with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg[0] <= EMPTY;
      state_reg[1] <= EMPTY;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      fill_cnt_reg <= '0;
    end else begin
      state_reg[0] <= state_next[0];
      state_reg[1] <= state_next[1];
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      fill_cnt_reg <= fill_cnt_next;
    end
  end

  // Next-state logic: the drained bank is always FULL and the written bank
  // never is, so drain and write/flush/commit touch different banks.
  always_comb begin
    state_next[0] = state_reg[0];
    state_next[1] = state_reg[1];
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    fill_cnt_next = fill_cnt_reg;

    if (drain) begin
      state_next[rd_ptr_reg] = EMPTY;
      rd_ptr_next            = ~rd_ptr_reg;
    end

    if (flush_i) begin
      fill_cnt_next = '0;
      if (state_reg[wr_ptr_reg] == FILLING) begin
        state_next[wr_ptr_reg] = EMPTY;
      end
    end else begin
      if (accept) begin
        if (completes) begin
          state_next[wr_ptr_reg] = FULL;
          fill_cnt_next          = '0;
          wr_ptr_next            = ~wr_ptr_reg;
        end else begin
          state_next[wr_ptr_reg] = FILLING;
          fill_cnt_next          = cnt_plus[CNT_W-1:0];
        end
      end
      if (commit_eff) begin
        state_next[wr_ptr_reg] = FULL;
        fill_cnt_next          = '0;
        wr_ptr_next            = ~wr_ptr_reg;
      end
    end
  end

  // Status outputs decoded from registered state only
  always_comb begin
    wr_ready_o  = (state_reg[wr_ptr_reg] != FULL);
    pim_valid_o = (state_reg[rd_ptr_reg] == FULL);
    full_o      = (state_reg[0] == FULL) && (state_reg[1] == FULL);
    empty_o     = (state_reg[0] == EMPTY) && (state_reg[1] == EMPTY) &&
                  (fill_cnt_reg == '0);
  end

  assign fill_cnt_o = fill_cnt_reg;
  assign pim_data_o = bank_data[rd_ptr_reg];

  // Two identical banks; only the one under wr_ptr sees write/clear/commit
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic sel;
    assign sel = (wr_ptr_reg == 1'(gi));

    pim_input_bank #(
      .DATA_W (DATA_W),
      .VEC_W  (VEC_W)
    ) u_bank (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .wr_en_i      (accept && sel),
      .wr_idx_i     (fill_cnt_reg),
      .wr_data_i    (wr_data_i),
      .clr_i        (flush_clr && sel),
      .trunc_en_i   (commit_eff && sel),
      .trunc_from_i (fill_cnt_reg),
      .data_o       (bank_data[gi])
    );
  end

endmodule
